// File: rtl/nvram_upload.sv
// CMOS NVRAM save/restore bridge between the HPS ioctl port and the core's nibble-wide CMOS RAM.
// Pauses the core CPU, services byte strobes one at a time and tracks whether CMOS has changed.
module nvram_upload #(
    parameter int NV_INDEX = 4,
    parameter int NV_SIZE  = 1024
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_upload,
    input  logic        ioctl_download,
    input  logic [15:0] ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic        ioctl_rd,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_dout,
    output logic [7:0]  ioctl_din,
    output logic        pause_req,
    input  logic        pause_ack,
    output logic [9:0]  ram_addr,
    output logic [3:0]  ram_wdata,
    output logic        ram_we,
    input  logic [3:0]  ram_rdata,
    input  logic        cpu_cmos_we,
    output logic        nv_dirty
);

    typedef enum logic [2:0] {
        S_IDLE, S_PAUSE, S_READY, S_FETCH, S_LATCH, S_WRITE, S_DRAIN
    } state_t;

    state_t      r_state, w_nxt;
    logic        r_active_d;
    logic        r_pend_vld, r_pend_rd;
    logic [24:0] r_pend_addr;
    logic [3:0]  r_pend_data;
    logic [9:0]  r_ram_addr;
    logic [3:0]  r_ram_wdata;
    logic [7:0]  r_din;
    logic        r_oor, r_hit_last, r_dirty;

    logic        w_active, w_rise, w_strobe;
    logic        w_issue, w_done;
    logic        w_op_rd, w_op_oor;
    logic [24:0] w_op_addr;
    logic [3:0]  w_op_data;
    logic        w_unused;

    assign w_unused = ^ioctl_dout[7:4];

    assign w_active = (ioctl_upload | ioctl_download) && (ioctl_index == 16'(NV_INDEX));
    assign w_rise   = w_active & ~r_active_d;
    // A strobe coinciding with the rising edge of active is kept rather than lost.
    assign w_strobe = w_active & (ioctl_rd | ioctl_wr) & ((r_state != S_IDLE) | w_rise);

    assign w_op_rd   = r_pend_vld ? r_pend_rd   : ioctl_rd;
    assign w_op_addr = r_pend_vld ? r_pend_addr : ioctl_addr;
    assign w_op_data = r_pend_vld ? r_pend_data : ioctl_dout[3:0];
    assign w_op_oor  = (w_op_addr >= 25'(NV_SIZE));

    always_comb begin
        w_nxt   = r_state;
        w_issue = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE:  if (w_rise) w_nxt = S_PAUSE;
            S_PAUSE: begin
                if (pause_ack)                     w_nxt = S_READY;
                else if (!w_active && !r_pend_vld) w_nxt = S_DRAIN;
            end
            S_READY: begin
                if (r_pend_vld || w_strobe) begin
                    w_issue = 1'b1;
                    if (w_op_rd)        w_nxt = S_FETCH;
                    else if (!w_op_oor) w_nxt = S_WRITE;
                end else if (!w_active) begin
                    w_nxt = S_DRAIN;
                end
            end
            S_FETCH: w_nxt = S_LATCH;
            S_LATCH: w_nxt = S_READY;
            S_WRITE: if (pause_ack) w_nxt = S_READY;
            S_DRAIN: begin
                w_nxt  = w_active ? S_PAUSE : S_IDLE;
                w_done = ~w_active;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_active_d  <= 1'b1;   // forces a fresh rising edge of active after reset
            r_pend_vld  <= 1'b0;
            r_pend_rd   <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_din       <= 8'h00;
            r_oor       <= 1'b0;
            r_hit_last  <= 1'b0;
            r_dirty     <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_active_d <= w_active;

            if (w_strobe && ((r_state == S_READY) ? r_pend_vld : !r_pend_vld)) begin
                r_pend_vld  <= 1'b1;
                r_pend_rd   <= ioctl_rd;
                r_pend_addr <= ioctl_addr;
                r_pend_data <= ioctl_dout[3:0];
            end else if ((r_state == S_READY) && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end

            if (w_rise) r_hit_last <= 1'b0;
            if (w_issue) begin
                r_oor <= w_op_oor;
                if (!w_op_oor) begin
                    r_ram_addr <= w_op_addr[9:0];
                    if (!w_op_rd) r_ram_wdata <= w_op_data;
                end
                if (w_op_addr == 25'(NV_SIZE - 1)) r_hit_last <= 1'b1;
            end

            if (r_state == S_LATCH) r_din <= r_oor ? 8'h00 : {4'h0, ram_rdata};

            if ((r_state == S_IDLE) && cpu_cmos_we) r_dirty <= 1'b1;
            else if (w_done && r_hit_last)          r_dirty <= 1'b0;
        end
    end

    assign pause_req = (r_state != S_IDLE);
    assign ram_we    = (r_state == S_WRITE) & pause_ack;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ioctl_din = r_din;
    assign nv_dirty  = r_dirty;

endmodule

// File: tb/tb_nvram_upload.sv
// Bench for nvram_upload: nibble RAM model driven by the DUT, plus an independent
// memory image and transfer rules used to predict every read, write and dirty flag.
module tb_nvram_upload;
    localparam int NV_INDEX = 4;
    localparam int NV_SIZE  = 1024;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload, ioctl_download;
    logic [15:0] ioctl_index;
    logic [24:0] ioctl_addr;
    logic        ioctl_rd, ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_din;
    logic        pause_req, pause_ack;
    logic [9:0]  ram_addr;
    logic [3:0]  ram_wdata;
    logic        ram_we;
    logic [3:0]  ram_rdata;
    logic        cpu_cmos_we;
    logic        nv_dirty;

    always #5 clk_sys = ~clk_sys;

    nvram_upload #(.NV_INDEX(NV_INDEX), .NV_SIZE(NV_SIZE)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .pause_req(pause_req), .pause_ack(pause_ack),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .cpu_cmos_we(cpu_cmos_we), .nv_dirty(nv_dirty)
    );

    logic [3:0] ram       [0:NV_SIZE-1];
    logic [3:0] mem_model [0:NV_SIZE-1];
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr;
    logic [3:0] bd_data;
    int         we_cnt = 0;
    int         we_viol = 0;
    logic [9:0] we_addr;
    logic [3:0] we_data;

    always @(posedge clk_sys) begin
        if (bd_we)       ram[bd_addr]  <= bd_data;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
        if (ram_we) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
            we_data <= ram_wdata;
            if (!pause_ack) we_viol <= we_viol + 1;
        end
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] last_exp = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [7:0] exp_rd(input logic [24:0] a);
        return (a < 25'(NV_SIZE)) ? {4'h0, mem_model[a[9:0]]} : 8'h00;
    endfunction

    task automatic start(input logic up, input logic [15:0] idx);
        ioctl_index    = idx;
        ioctl_upload   = up;
        ioctl_download = ~up;
        tick();
        tick();
    endtask

    task automatic stop();
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic do_read(input logic [24:0] a);
        logic [7:0] e;
        e = exp_rd(a);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        check_val("rd_hold", ioctl_din, last_exp);
        tick();
        check_val("rd_data", ioctl_din, e);
        check_val("rd_pause", pause_req, 1'b1);
        last_exp = e;
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d);
        int c0;
        c0 = we_cnt;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        tick();
        tick();
        if (a < 25'(NV_SIZE)) begin
            mem_model[a[9:0]] = d[3:0];
            check_val("wr_pulses", we_cnt - c0, 1);
            check_val("wr_ram", ram[a[9:0]], d[3:0]);
        end else begin
            check_val("wr_oor_pulses", we_cnt - c0, 0);
        end
    endtask

    function automatic logic [24:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 25'(NV_SIZE) + 25'($urandom_range(0, 5000));
        return 25'($urandom_range(0, NV_SIZE - 2));
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0]  sv_addr;
        logic [24:0] a;
        logic [7:0]  e;
        logic        early;
        int          c0, waited;
        logic [9:0]  y, z;
        logic [3:0]  zold;

        reset_n = 1'b0;
        ioctl_upload = 0; ioctl_download = 0; ioctl_index = 0; ioctl_addr = 0;
        ioctl_rd = 0; ioctl_wr = 0; ioctl_dout = 0; pause_ack = 1'b1; cpu_cmos_we = 0;
        #3;
        check_val("rst_pause_req", pause_req, 1'b0);
        check_val("rst_ram_we", ram_we, 1'b0);
        check_val("rst_ram_addr", ram_addr, 10'h0);
        check_val("rst_ram_wdata", ram_wdata, 4'h0);
        check_val("rst_din", ioctl_din, 8'h00);
        check_val("rst_dirty", nv_dirty, 1'b0);

        for (int i = 0; i < NV_SIZE; i++) begin
            bd_we   = 1'b1;
            bd_addr = 10'(i);
            bd_data = (i == 5) ? 4'hA : 4'($urandom_range(0, 15));
            mem_model[i] = bd_data;
            tick();
        end
        bd_we = 1'b0;
        reset_n = 1'b1;
        tick();

        cpu_cmos_we = 1'b1; tick(); cpu_cmos_we = 1'b0;
        check_val("dirty_set", nv_dirty, 1'b1);

        start(1'b1, 16'(NV_INDEX));
        check_val("up_pause_req", pause_req, 1'b1);
        do_read(25'd5);
        sv_addr = ram_addr;
        do_read(25'd1024);
        check_val("oor_ram_addr", ram_addr, sv_addr);
        do_read(25'h100_0005);
        for (int i = 0; i < 40; i++) do_read(rand_addr());
        stop();
        check_val("up_end_pause", pause_req, 1'b0);
        check_val("dirty_no_last", nv_dirty, 1'b1);

        start(1'b0, 16'(NV_INDEX));
        do_write(25'd1023, 8'h37);
        check_val("dl_we_addr", we_addr, 10'h3FF);
        check_val("dl_we_data", we_data, 4'h7);
        for (int i = 0; i < 30; i++) do_write(rand_addr(), 8'($urandom_range(0, 255)));
        stop();
        check_val("dl_dirty_clear", nv_dirty, 1'b0);
        check_val("dl_end_pause", pause_req, 1'b0);

        start(1'b1, 16'(NV_INDEX));
        for (int i = 0; i < 30; i++) do_read(rand_addr());
        // read, then a write while busy (pended), then a third strobe that must be dropped
        c0 = we_cnt;
        a = 25'($urandom_range(0, 500));
        y = 10'($urandom_range(501, 700));
        z = 10'($urandom_range(701, 900));
        zold = mem_model[z];
        e = exp_rd(a);
        ioctl_addr = a; ioctl_rd = 1'b1; tick(); ioctl_rd = 1'b0;
        ioctl_addr = 25'(y); ioctl_dout = 8'h5C; ioctl_wr = 1'b1; tick();
        ioctl_addr = 25'(z); ioctl_dout = {4'h0, ~zold}; tick();
        ioctl_wr = 1'b0;
        check_val("busy_rd_data", ioctl_din, e);
        last_exp = e;
        tick(); tick(); tick(); tick();
        mem_model[y] = 4'hC;
        check_val("pend_we_cnt", we_cnt - c0, 1);
        check_val("pend_ram_y", ram[y], mem_model[y]);
        check_val("drop_ram_z", ram[z], zold);
        stop();

        c0 = we_cnt;
        start(1'b0, 16'd0);
        ioctl_addr = 25'd7; ioctl_dout = 8'h3; ioctl_wr = 1'b1; tick(); ioctl_wr = 1'b0;
        tick(); tick();
        check_val("idx0_no_we", we_cnt - c0, 0);
        check_val("idx0_pause", pause_req, 1'b0);
        ioctl_download = 1'b0;
        tick();

        // delayed pause_ack: read strobe lands in PAUSE and is serviced after the ack
        do a = 25'($urandom_range(0, NV_SIZE - 2)); while (exp_rd(a) == last_exp);
        e = exp_rd(a);
        pause_ack = 1'b0;
        early = 1'b0;
        ioctl_index = 16'(NV_INDEX); ioctl_upload = 1'b1;
        tick();
        for (int cyc = 1; cyc < 10; cyc++) begin
            if (cyc == 2) begin ioctl_addr = a; ioctl_rd = 1'b1; end
            else ioctl_rd = 1'b0;
            tick();
            if (ioctl_din != last_exp) early = 1'b1;
        end
        ioctl_rd = 1'b0;
        check_val("ack_no_early", early, 1'b0);
        check_val("ack_pause_held", pause_req, 1'b1);
        pause_ack = 1'b1;
        waited = 0;
        while (ioctl_din != e && waited < 20) begin tick(); waited++; end
        check_val("ack_rd_data", ioctl_din, e);
        last_exp = e;
        check_val("we_without_ack", we_viol, 0);
        stop();

        // reset asserted while a write is in its WRITE cycle
        c0 = we_cnt;
        y = 10'($urandom_range(0, 900));
        zold = mem_model[y];
        start(1'b0, 16'(NV_INDEX));
        ioctl_addr = 25'(y); ioctl_dout = {4'h0, ~zold}; ioctl_wr = 1'b1; tick(); ioctl_wr = 1'b0;
        check_val("rstw_we_before", ram_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check_val("rstw_we_now", ram_we, 1'b0);
        check_val("rstw_pause_now", pause_req, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        last_exp = 8'h00;
        tick(); tick(); tick(); tick();
        check_val("rstw_wait_idle", pause_req, 1'b0);
        check_val("rstw_no_we", we_cnt - c0, 0);
        check_val("rstw_ram", ram[y], zold);
        check_val("rstw_din", ioctl_din, 8'h00);
        ioctl_download = 1'b0;
        tick();
        cpu_cmos_we = 1'b1; tick(); cpu_cmos_we = 1'b0;
        check_val("dirty_after_rst", nv_dirty, 1'b1);

        start(1'b1, 16'(NV_INDEX));
        do_read(25'd1023);
        stop();
        check_val("up_last_clears", nv_dirty, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
